alusrc_fwd_stage: RTL
=====================

// Module: alusrc_fwd_stage
// PURPOSE
//  Pipelined successor of the ALU operand-B select. Picks operand B from register, sign-extended
//  immediate, shamt or upper-immediate, overriding the register with forwarded data. Stalls on
//  load-use hazards and holds the result in a valid/ready output register at the ID/EX boundary.
// PARAMETERS
//  WIDTH     32  datapath width (even, >= 2*SHAMT_W)
//  NUM_FWD   2   forwarding sources; index 0 = youngest (EX/MEM), highest priority
//  SHAMT_W   5   shift-amount width
//  MAX_WAIT  4   max cycles in WAIT_FWD before forced fallback (>= 1)
//  CNT_W     16  width of forwarded-operand counter
// PORTS
//  clk            in   1              rising-edge clock
//  reset_n        in   1              synchronous reset, active low
//  flush          in   1              discard in-flight operand (branch/exception)
//  in_valid       in   1              upstream operand request valid
//  in_ready       out  1              stage accepts request this cycle
//  read_data2     in   WIDTH          register-file operand
//  sign_extended  in   WIDTH          sign-extended immediate
//  shamt          in   SHAMT_W        shift amount
//  alusrc         in   2              00 reg, 01 imm, 10 shamt, 11 upper-imm
//  rs2_addr       in   5              source register of read_data2
//  fwd_valid      in   NUM_FWD        source i writes a register
//  fwd_pending    in   NUM_FWD        source i data not yet available (load in flight)
//  fwd_addr       in   NUM_FWD*5      destination register per source, packed, source i at [5i+:5]
//  fwd_data       in   NUM_FWD*WIDTH  data per source, packed, source i at [WIDTH*i+:WIDTH]
//  out_valid      out  1              alusrc_result valid
//  out_ready      in   1              downstream (ALU) accepts result
//  alusrc_result  out  WIDTH          selected operand B, registered
//  fwd_count      out  CNT_W          saturating count of delivered forwarded operands
//  wait_timeout   out  1              sticky: MAX_WAIT expired at least once
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state IDLE, out_valid=0, alusrc_result=0, fwd_count=0,
//   wait_timeout=0, wait counter 0, hold registers 0.
//  Match: source i hits iff fwd_valid[i] && fwd_addr[i]==rs2_addr && rs2_addr!=0.
//   Lowest hitting index wins. Only the winner's fwd_pending matters.
//   Matching applies only for alusrc==00; other modes never forward or stall.
//  Resolvable: no hit, or winner not pending. Register operand = winner fwd_data, else read_data2.
//  Mode results:
//   01 = sign_extended.
//   10 = shamt zero-extended to WIDTH.
//   11 = sign_extended << (WIDTH/2), low half zero.
//  FSM (encodings in package):
//   IDLE: in_ready=1, out_valid=0. Accept with in_valid=1:
//    - resolvable -> result registered -> OUT (latency 1 cycle);
//    - not resolvable -> latch read_data2/rs2_addr/alusrc -> WAIT_FWD, counter=0.
//   WAIT_FWD: in_ready=0, out_valid=0. Each cycle re-evaluates the match on latched rs2_addr
//    against live fwd_* inputs.
//    - resolvable -> register winner data (or latched read_data2 if hit vanished) -> OUT;
//    - else counter++; at counter==MAX_WAIT-1 register latched read_data2, set wait_timeout -> OUT.
//   OUT: out_valid=1, alusrc_result held stable until out_ready=1; in_ready=out_ready.
//    - out_ready && in_valid: new request processed exactly as from IDLE (back-to-back, 1/cycle);
//    - out_ready && !in_valid -> IDLE.
//  fwd_count increments by 1 on each transfer out (out_valid && out_ready) whose operand came from
//   fwd_data. Saturates at all-ones.
//  flush (reset_n=1): highest priority. Next state IDLE, out_valid=0, counter=0.
//   in_ready=0 during the flush cycle; an in_valid request that cycle is dropped.
//   fwd_count and wait_timeout are kept.
//  Reset overrides flush. Reset mid-WAIT_FWD or mid-OUT discards the operand.
//  Unknown state encoding -> IDLE.
// STRUCTURE
//  Shared package alusrc_pkg:
//   ALUSRC_REG/IMM/SHAMT/UPPER (2-bit); FSM state codes IDLE/WAIT_FWD/OUT.
//  Sub-module fwd_select (combinational, parametrised NUM_FWD/WIDTH):
//   outputs hit, winner_pending, winner_data.
//  Top: FSM, hold registers, output register, counters.
// TESTING
//  1 alusrc=00, read_data2=A5A5A5A5, no fwd_valid, out_ready=1
//    -> next cycle out_valid=1, result A5A5A5A5, fwd_count 0.
//  2 alusrc=01/10/11, sign_extended=FFFF8001, shamt=1F
//    -> results FFFF8001 / 0000001F / 80010000; fwd_valid hits ignored.
//  3 rs2=5; fwd0 and fwd1 both addr 5, data 11111111/22222222
//    -> 11111111, fwd_count 1.
//    Repeat with rs2=0 -> read_data2.
//  4 rs2=7; fwd0 addr 7, pending for 2 cycles
//    -> in_ready=0 for 2 cycles, then fwd data 12345678 delivered.
//    Held pending -> read_data2 after MAX_WAIT cycles, wait_timeout=1.
//  5 out_ready=0 for 3 cycles with result DEADBEEF
//    -> result stable, in_ready=0.
//    Then back-to-back 4 requests with out_ready=1 -> one result per cycle, in order.
//  6 flush in WAIT_FWD and in OUT -> out_valid=0 next cycle.
//    Simultaneous in_valid dropped.
//    reset_n=0 mid-OUT -> all outputs at reset values.

Source files
------------

// File: rtl/alusrc_pkg.sv
// Shared encodings for the ALU operand-B select stage: alusrc modes,
// register address width and FSM state codes.
package alusrc_pkg;

   localparam logic [1:0] ALUSRC_REG   = 2'b00;
   localparam logic [1:0] ALUSRC_IMM   = 2'b01;
   localparam logic [1:0] ALUSRC_SHAMT = 2'b10;
   localparam logic [1:0] ALUSRC_UPPER = 2'b11;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_FWD = 2'b01,
      OUT      = 2'b10
   } state_t;

endpackage

// File: rtl/alusrc_fwd_stage_fwd_select.sv
// Combinational forwarding match: finds the lowest-index (youngest) source
// writing rs2_addr and reports its data and pending flag.
module fwd_select
   import alusrc_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int WIDTH   = 32
) (
   input  logic                          match_en,
   input  logic [REG_ADDR_W-1:0]         rs2_addr,
   input  logic [NUM_FWD-1:0]            fwd_valid,
   input  logic [NUM_FWD-1:0]            fwd_pending,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD*WIDTH-1:0]      fwd_data,
   output logic                          hit,
   output logic                          winner_pending,
   output logic [WIDTH-1:0]              winner_data
);

   always_comb begin
      hit            = 1'b0;
      winner_pending = 1'b0;
      winner_data    = '0;
      // Walk from oldest to youngest so the lowest hitting index is the last writer.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (match_en && rs2_addr != '0 && fwd_valid[i] &&
             fwd_addr[REG_ADDR_W*i +: REG_ADDR_W] == rs2_addr) begin
            hit            = 1'b1;
            winner_pending = fwd_pending[i];
            winner_data    = fwd_data[WIDTH*i +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/alusrc_fwd_stage.sv
// ID/EX operand-B select with forwarding override, load-use stall with a
// bounded wait, and a valid/ready output register.
module alusrc_fwd_stage
   import alusrc_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_FWD  = 2,
   parameter int SHAMT_W  = 5,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              read_data2,
   input  logic [WIDTH-1:0]              sign_extended,
   input  logic [SHAMT_W-1:0]            shamt,
   input  logic [1:0]                    alusrc,
   input  logic [REG_ADDR_W-1:0]         rs2_addr,
   input  logic [NUM_FWD-1:0]            fwd_valid,
   input  logic [NUM_FWD-1:0]            fwd_pending,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD*WIDTH-1:0]      fwd_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              alusrc_result,
   output logic [CNT_W-1:0]              fwd_count,
   output logic                          wait_timeout
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_t                  state, state_next;
   logic [WAIT_W-1:0]       wait_cnt, cnt_next;
   logic [WIDTH-1:0]        hold_rd2;
   logic [REG_ADDR_W-1:0]   hold_rs2;
   logic [1:0]              hold_alusrc;
   logic                    from_fwd_q;

   logic [REG_ADDR_W-1:0]   sel_rs2;
   logic                    match_en, hit, winner_pending, resolvable;
   logic [WIDTH-1:0]        winner_data, req_result, result_next;
   logic                    req_from_fwd, from_fwd_next;
   logic                    load_result, latch_hold, set_timeout;

   // While stalled, the match runs on the latched request against live forwarding inputs.
   assign sel_rs2    = (state == WAIT_FWD) ? hold_rs2 : rs2_addr;
   assign match_en   = (state == WAIT_FWD) ? (hold_alusrc == ALUSRC_REG) : (alusrc == ALUSRC_REG);
   assign resolvable = !(hit && winner_pending);

   fwd_select #(.NUM_FWD(NUM_FWD), .WIDTH(WIDTH)) u_fwd_select (
      .match_en       (match_en),
      .rs2_addr       (sel_rs2),
      .fwd_valid      (fwd_valid),
      .fwd_pending    (fwd_pending),
      .fwd_addr       (fwd_addr),
      .fwd_data       (fwd_data),
      .hit            (hit),
      .winner_pending (winner_pending),
      .winner_data    (winner_data)
   );

   always_comb begin
      req_result   = hit ? winner_data : read_data2;
      req_from_fwd = hit;
      case (alusrc)
         ALUSRC_IMM:   begin req_result = sign_extended;  req_from_fwd = 1'b0; end
         ALUSRC_SHAMT: begin req_result = WIDTH'(shamt);  req_from_fwd = 1'b0; end
         ALUSRC_UPPER: begin
            req_result   = {sign_extended[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            req_from_fwd = 1'b0;
         end
         default: ;
      endcase
   end

   // Next-state and datapath-load decisions.
   always_comb begin
      state_next    = state;
      cnt_next      = wait_cnt;
      load_result   = 1'b0;
      latch_hold    = 1'b0;
      set_timeout   = 1'b0;
      result_next   = req_result;
      from_fwd_next = req_from_fwd;
      if (flush) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE, OUT: begin
               if (state == IDLE || out_ready) begin
                  if (!in_valid) begin
                     state_next = IDLE;
                  end else if (resolvable) begin
                     load_result = 1'b1;
                     state_next  = OUT;
                  end else begin
                     latch_hold = 1'b1;
                     cnt_next   = '0;
                     state_next = WAIT_FWD;
                  end
               end
            end
            WAIT_FWD: begin
               if (resolvable) begin
                  load_result   = 1'b1;
                  result_next   = hit ? winner_data : hold_rd2;
                  from_fwd_next = hit;
                  cnt_next      = '0;
                  state_next    = OUT;
               end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                  load_result   = 1'b1;
                  result_next   = hold_rd2;
                  from_fwd_next = 1'b0;
                  set_timeout   = 1'b1;
                  cnt_next      = '0;
                  state_next    = OUT;
               end else begin
                  cnt_next = wait_cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready = !flush;
         OUT: begin
            out_valid = 1'b1;
            in_ready  = out_ready && !flush;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         wait_cnt <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_rd2      <= '0;
         hold_rs2      <= '0;
         hold_alusrc   <= ALUSRC_REG;
         alusrc_result <= '0;
         from_fwd_q    <= 1'b0;
         fwd_count     <= '0;
         wait_timeout  <= 1'b0;
      end else begin
         if (latch_hold) begin
            hold_rd2    <= read_data2;
            hold_rs2    <= rs2_addr;
            hold_alusrc <= alusrc;
         end
         if (load_result) begin
            alusrc_result <= result_next;
            from_fwd_q    <= from_fwd_next;
         end
         if (set_timeout)
            wait_timeout <= 1'b1;
         if (out_valid && out_ready && from_fwd_q && !flush && fwd_count != '1)
            fwd_count <= fwd_count + 1'b1;
      end
   end

endmodule
